// File: rtl/wire_pipe_pkg.sv
// Shared constants and sizing helpers for the wire_pipe elastic pipeline.
package wire_pipe_pkg;

  localparam int MAX_DEPTH = 16;

  // Occupancy counter width; a zero-depth pipe still exposes a 1-bit count.
  function automatic int CNT_W(input int d);
    if (d == 0) begin
      return 1;
    end else begin
      return $clog2(d + 1);
    end
  endfunction

endpackage

// File: rtl/wire_pipe_if.sv
// Valid/ready/data stream bundle; master drives valid and data, slave drives ready.
interface wire_pipe_if #(
  parameter int WIDTH = 8
);

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/wire_pipe_stage.sv
// One elastic register slot: takes a new item whenever it is empty or its
// current item is leaving in the same cycle.
module wire_pipe_stage
  import wire_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  assign in_ready  = ~valid_r | out_ready;
  assign out_valid = valid_r;
  assign out_data  = data_r;

  // Slot register; data only loads with a valid item so a bubble keeps the old value.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (in_ready) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

endmodule

// File: rtl/wire_pipe.sv
// Elastic, order-preserving register pipeline of DEPTH slots with flush and
// occupancy count; DEPTH=0 collapses to a plain combinational wire.
module wire_pipe
  import wire_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  wire_pipe_if.slave                 s,
  wire_pipe_if.master                m,
  output logic [CNT_W(DEPTH)-1:0]    count
);

  localparam int CW = CNT_W(DEPTH);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_s;

      assign m.valid  = s.valid;
      assign m.data   = s.data;
      assign s.ready  = m.ready;
      assign count    = '0;
      assign unused_s = clk ^ reset ^ flush;
    end else begin : g_pipe
      logic [DEPTH:0]   vld_s;
      logic [WIDTH-1:0] dat_s [DEPTH+1];
      logic             s_ready_s;
      logic             push_s;
      logic             pop_s;
      logic [CW-1:0]    count_r;

      assign vld_s[0] = s.valid;
      assign dat_s[0] = s.data;

      // Each slot owns its ready net so the backward ripple is a chain of distinct signals.
      for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic rdy_s;
        logic nxt_rdy_s;

        if (i == DEPTH - 1) begin : g_last
          assign nxt_rdy_s = m.ready;
        end else begin : g_mid
          assign nxt_rdy_s = g_stage[i+1].rdy_s;
        end

        wire_pipe_stage #(
          .WIDTH (WIDTH)
        ) u_stage (
          .clk       (clk),
          .reset     (reset),
          .flush     (flush),
          .in_valid  (vld_s[i]),
          .in_ready  (rdy_s),
          .in_data   (dat_s[i]),
          .out_valid (vld_s[i+1]),
          .out_ready (nxt_rdy_s),
          .out_data  (dat_s[i+1])
        );
      end

      assign s_ready_s = g_stage[0].rdy_s & ~flush & ~reset;
      assign s.ready   = s_ready_s;
      assign m.valid   = vld_s[DEPTH];
      assign m.data    = dat_s[DEPTH];

      assign push_s = s.valid & s_ready_s;
      assign pop_s  = vld_s[DEPTH] & m.ready;

      // Occupancy tracks handshakes; a pop during flush still leaves the pipe empty.
      always_ff @(posedge clk) begin
        if (reset) begin
          count_r <= '0;
        end else if (flush) begin
          count_r <= '0;
        end else begin
          count_r <= count_r + CW'(push_s) - CW'(pop_s);
        end
      end

      assign count = count_r;
    end
  endgenerate

endmodule

// File: tb/tb_wire_pipe.sv
// Self-checking bench for wire_pipe: slot-position model for DEPTH=3 plus
// directed literal checks, and a combinational check of a DEPTH=0 instance.
module tb_wire_pipe;
  import wire_pipe_pkg::*;

  localparam int W = 8;
  localparam int D = 3;

  logic clk = 1'b0;
  logic reset;
  logic flush;
  logic [CNT_W(D)-1:0] count;
  logic [CNT_W(0)-1:0] count0;

  wire_pipe_if #(.WIDTH(W)) s_if ();
  wire_pipe_if #(.WIDTH(W)) m_if ();
  wire_pipe_if #(.WIDTH(W)) s0_if ();
  wire_pipe_if #(.WIDTH(W)) m0_if ();

  wire_pipe #(.WIDTH(W), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .s     (s_if),
    .m     (m_if),
    .count (count)
  );

  wire_pipe #(.WIDTH(W), .DEPTH(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .s     (s0_if),
    .m     (m0_if),
    .count (count0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  logic [7:0] acc_dat [$];
  logic [7:0] out_dat [$];
  int         acc_cyc [$];
  int         out_cyc [$];

  // Model: each held item has a slot position 0..D-1, oldest first.
  int         mpos [$];
  logic [7:0] mdat [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : model_chk
    int np [$];
    int cap;
    int p;
    bit mv_e;
    bit pop_e;
    bit sr_e;
    bit push_e;
    if (cmp_en) begin
      mv_e  = (mpos.size() > 0) && (mpos[0] == D - 1);
      pop_e = mv_e && m_if.ready;
      np.delete();
      cap = D - 1;
      // An item moves up one slot unless the slot ahead stays occupied.
      for (int k = (pop_e ? 1 : 0); k < mpos.size(); k++) begin
        p = (mpos[k] + 1 <= cap) ? mpos[k] + 1 : mpos[k];
        np.push_back(p);
        cap = p - 1;
      end
      sr_e   = !reset && !flush && (cap >= 0);
      push_e = sr_e && s_if.valid;

      chk("mdl_m_valid", 32'(m_if.valid), 32'(mv_e));
      if (mv_e) chk("mdl_m_data", 32'(m_if.data), 32'(mdat[0]));
      chk("mdl_s_ready", 32'(s_if.ready), 32'(sr_e));
      chk("mdl_count", 32'(count), mpos.size());

      if (s_if.valid && s_if.ready) begin
        acc_dat.push_back(s_if.data);
        acc_cyc.push_back(cyc);
      end
      if (m_if.valid && m_if.ready) begin
        out_dat.push_back(m_if.data);
        out_cyc.push_back(cyc);
      end

      if (reset) begin
        mpos.delete();
        mdat.delete();
      end else begin
        if (pop_e) void'(mdat.pop_front());
        mpos = np;
        if (flush) begin
          mpos.delete();
          mdat.delete();
        end else if (push_e) begin
          mpos.push_back(0);
          mdat.push_back(s_if.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_dat.delete();
    out_dat.delete();
    acc_cyc.delete();
    out_cyc.delete();
  endtask

  initial begin
    int nxt;
    int guard;
    reset = 1'b1;
    flush = 1'b0;
    s_if.valid = 1'b0;
    s_if.data  = 8'h00;
    m_if.ready = 1'b0;
    s0_if.valid = 1'b0;
    s0_if.data  = 8'h00;
    m0_if.ready = 1'b0;

    // Reset state
    step();
    cmp_en = 1'b1;
    @(negedge clk);
    chk("rst_s_ready", 32'(s_if.ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_m_valid", 32'(m_if.valid), 32'd0);
    chk("rst_m_data", 32'(m_if.data), 32'd0);
    step();
    reset = 1'b0;

    // 1: back-to-back stream 0x01..0x10
    clear_logs();
    m_if.ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 8'(i);
      @(negedge clk);
      if (i == 6 || i == 12) chk("t1_count", 32'(count), 32'd3);
      step();
    end
    s_if.valid = 1'b0;
    repeat (6) step();
    chk("t1_n_out", out_dat.size(), 32'd16);
    if (acc_cyc.size() > 0 && out_cyc.size() > 0)
      chk("t1_latency", out_cyc[0] - acc_cyc[0], 32'd3);
    for (int k = 0; k < out_dat.size(); k++) begin
      chk("t1_order", 32'(out_dat[k]), k + 1);
      chk("t1_gap", out_cyc[k] - out_cyc[0], k);
    end

    // 2: stall fills the pipe, then release
    clear_logs();
    m_if.ready = 1'b0;
    nxt = 1;
    for (int i = 0; i < 6; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 8'(nxt);
      @(negedge clk);
      if (s_if.ready) nxt++;
      step();
    end
    s_if.data = 8'(nxt);
    @(negedge clk);
    chk("t2_n_acc", acc_dat.size(), 32'd3);
    chk("t2_s_ready", 32'(s_if.ready), 32'd0);
    chk("t2_count", 32'(count), 32'd3);
    chk("t2_m_valid", 32'(m_if.valid), 32'd1);
    chk("t2_m_data", 32'(m_if.data), 32'h01);
    step();
    m_if.ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_if.valid = 1'b1;
      s_if.data  = 8'(nxt);
      @(negedge clk);
      if (s_if.ready) nxt++;
      step();
    end
    s_if.valid = 1'b0;
    repeat (6) step();
    chk("t2_n_out", out_dat.size(), 32'd11);
    for (int k = 0; k < out_dat.size(); k++) begin
      chk("t2_order", 32'(out_dat[k]), k + 1);
      chk("t2_gap", out_cyc[k] - out_cyc[0], k);
    end

    // 3: flush with two items held, then a fresh push
    clear_logs();
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 8'hA1;
    step();
    s_if.data  = 8'hA2;
    step();
    s_if.valid = 1'b0;
    @(negedge clk);
    chk("t3_count_2", 32'(count), 32'd2);
    step();
    flush      = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 8'hB0;
    @(negedge clk);
    chk("t3_flush_s_ready", 32'(s_if.ready), 32'd0);
    step();
    flush      = 1'b0;
    s_if.valid = 1'b0;
    @(negedge clk);
    chk("t3_count_0", 32'(count), 32'd0);
    chk("t3_m_valid_0", 32'(m_if.valid), 32'd0);
    step();
    clear_logs();
    m_if.ready = 1'b1;
    s_if.valid = 1'b1;
    s_if.data  = 8'hC3;
    step();
    s_if.valid = 1'b0;
    repeat (5) step();
    chk("t3_n_acc", acc_dat.size(), 32'd1);
    chk("t3_n_out", out_dat.size(), 32'd1);
    if (acc_cyc.size() > 0 && out_cyc.size() > 0) begin
      chk("t3_out_data", 32'(out_dat[0]), 32'hC3);
      chk("t3_latency", out_cyc[0] - acc_cyc[0], 32'd3);
    end

    // 3b: flush on a full pipe while the head is being popped
    clear_logs();
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    s_if.data  = 8'hD1;
    step();
    s_if.data  = 8'hD2;
    step();
    s_if.data  = 8'hD3;
    step();
    s_if.valid = 1'b0;
    @(negedge clk);
    chk("t3b_count_3", 32'(count), 32'd3);
    step();
    m_if.ready = 1'b1;
    flush      = 1'b1;
    @(negedge clk);
    chk("t3b_m_valid", 32'(m_if.valid), 32'd1);
    chk("t3b_s_ready", 32'(s_if.ready), 32'd0);
    step();
    flush      = 1'b0;
    m_if.ready = 1'b0;
    @(negedge clk);
    chk("t3b_count_0", 32'(count), 32'd0);
    chk("t3b_m_valid_0", 32'(m_if.valid), 32'd0);
    chk("t3b_n_out", out_dat.size(), 32'd1);
    if (out_dat.size() > 0) chk("t3b_popped", 32'(out_dat[0]), 32'hD1);
    step();

    // 4: reset mid-stream with a full pipe
    m_if.ready = 1'b0;
    s_if.valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      s_if.data = 8'hE0 + 8'(i);
      step();
    end
    @(negedge clk);
    chk("t4_count_3", 32'(count), 32'd3);
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("t4_s_ready_rst", 32'(s_if.ready), 32'd0);
    step();
    reset      = 1'b0;
    s_if.valid = 1'b0;
    @(negedge clk);
    chk("t4_m_valid", 32'(m_if.valid), 32'd0);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_m_data", 32'(m_if.data), 32'h00);
    chk("t4_s_ready", 32'(s_if.ready), 32'd1);
    step();
    m_if.ready = 1'b1;
    repeat (2) step();

    // 5: DEPTH=0 is a wire, sampled around both clock edges
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      s0_if.valid = 1'($urandom_range(0, 1));
      s0_if.data  = 8'($urandom);
      m0_if.ready = 1'($urandom_range(0, 1));
      #1;
      chk("t5_m_data", 32'(m0_if.data), 32'(s0_if.data));
      chk("t5_m_valid", 32'(m0_if.valid), 32'(s0_if.valid));
      chk("t5_s_ready", 32'(s0_if.ready), 32'(m0_if.ready));
      @(negedge clk);
      s0_if.valid = 1'($urandom_range(0, 1));
      s0_if.data  = 8'($urandom);
      m0_if.ready = 1'($urandom_range(0, 1));
      #1;
      chk("t5_m_data", 32'(m0_if.data), 32'(s0_if.data));
      chk("t5_m_valid", 32'(m0_if.valid), 32'(s0_if.valid));
      chk("t5_s_ready", 32'(s0_if.ready), 32'(m0_if.ready));
      chk("t5_count", 32'(count0), 32'd0);
    end
    step();

    // 6: random traffic, 1000 items, scoreboard on order
    clear_logs();
    guard = 0;
    while (acc_dat.size() < 1000 && guard < 20000) begin
      s_if.valid = 1'($urandom_range(0, 1));
      s_if.data  = 8'($urandom);
      m_if.ready = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    chk("t6_items", acc_dat.size(), 32'd1000);
    s_if.valid = 1'b0;
    m_if.ready = 1'b1;
    repeat (8) step();
    chk("t6_sb_size", out_dat.size(), acc_dat.size());
    for (int k = 0; k < out_dat.size() && k < acc_dat.size(); k++) begin
      chk("t6_sb_order", 32'(out_dat[k]), 32'(acc_dat[k]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
